// File: rtl/m68k_bus_responder.sv
// Slave end of the asynchronous 68000 bus: turns each CPU bus cycle into one req/ack device
// transaction, answers IACK with autovector. Define M68K_BERR_TIMEOUT_EN for bus-error timeout.
module m68k_bus_responder #(
    parameter int WAIT_STATES = 0,
    parameter int TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] a_in,
    input  logic [15:0] cpu_dout,
    output logic [15:0] cpu_din,
    input  logic        as_n,
    input  logic        uds_n,
    input  logic        lds_n,
    input  logic        r_w_n,
    input  logic [2:0]  fc,
    output logic        dtack_n,
    output logic        berr_n,
    output logic        avec_n,
    output logic        dev_req,
    output logic        dev_we,
    output logic [1:0]  dev_be,
    output logic [22:0] dev_addr,
    output logic [15:0] dev_wdata,
    input  logic [15:0] dev_rdata,
    input  logic        dev_ack
);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ACK,
        S_IACK
`ifdef M68K_BERR_TIMEOUT_EN
        , S_BERR
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic        dtack_n_q, dtack_n_d;
    logic        avec_n_q, avec_n_d;
    logic        dev_req_q, dev_req_d;
    logic        dev_we_q, dev_we_d;
    logic [1:0]  dev_be_q, dev_be_d;
    logic [22:0] dev_addr_q, dev_addr_d;
    logic [15:0] dev_wdata_q, dev_wdata_d;
    logic [15:0] cpu_din_q, cpu_din_d;

`ifdef M68K_BERR_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] tmo_q, tmo_d;
    logic       berr_n_q, berr_n_d;
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT);
`endif

    logic is_iack;
    logic any_strobe;
    logic unused_a0;

    assign is_iack    = (fc == 3'b111) && (a_in[19:16] == 4'hF);
    assign any_strobe = ~uds_n | ~lds_n;
    assign unused_a0  = a_in[0];

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a latch behind.
        state_d     = state_q;
        wait_d      = wait_q;
        dtack_n_d   = dtack_n_q;
        avec_n_d    = avec_n_q;
        dev_req_d   = dev_req_q;
        dev_we_d    = dev_we_q;
        dev_be_d    = dev_be_q;
        dev_addr_d  = dev_addr_q;
        dev_wdata_d = dev_wdata_q;
        cpu_din_d   = cpu_din_q;
`ifdef M68K_BERR_TIMEOUT_EN
        tmo_d       = tmo_q;
        berr_n_d    = berr_n_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (!as_n) begin
                    if (is_iack) begin
                        avec_n_d = 1'b0;
                        state_d  = S_IACK;
                    end else if (any_strobe) begin
                        // Writes arrive with strobes one cycle after AS; we simply wait for them.
                        dev_addr_d  = a_in[23:1];
                        dev_be_d    = {~uds_n, ~lds_n};
                        dev_we_d    = ~r_w_n;
                        dev_wdata_d = cpu_dout;
                        dev_req_d   = 1'b1;
                        state_d     = S_REQ;
`ifdef M68K_BERR_TIMEOUT_EN
                        tmo_d       = 8'd0;
`endif
                    end
                end
            end

            S_REQ: begin
                if (dev_ack) begin
                    dev_req_d = 1'b0;
                    if (!dev_we_q) cpu_din_d = dev_rdata;
                    wait_d  = WAIT_LOAD;
                    state_d = (WAIT_LOAD != 4'd0) ? S_WAIT : S_ACK;
                end else if (as_n) begin
                    dev_req_d = 1'b0;
                    state_d   = S_IDLE;
                end
`ifdef M68K_BERR_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    dev_req_d = 1'b0;
                    berr_n_d  = 1'b0;
                    state_d   = S_BERR;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end

            S_WAIT: begin
                wait_d = wait_q - 4'd1;
                if (as_n) state_d = S_IDLE;
                else if (wait_q == 4'd1) state_d = S_ACK;
            end

            S_ACK: begin
                dtack_n_d = as_n;
                if (as_n) state_d = S_IDLE;
            end

            S_IACK: begin
                if (as_n) begin
                    avec_n_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end

`ifdef M68K_BERR_TIMEOUT_EN
            S_BERR: begin
                if (as_n) begin
                    berr_n_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
`endif

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values, whatever the order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: only control and output flops exist here; all of them take reset values.
            state_q     <= S_IDLE;
            wait_q      <= 4'd0;
            dtack_n_q   <= 1'b1;
            avec_n_q    <= 1'b1;
            dev_req_q   <= 1'b0;
            dev_we_q    <= 1'b0;
            dev_be_q    <= 2'b00;
            dev_addr_q  <= 23'd0;
            dev_wdata_q <= 16'd0;
            cpu_din_q   <= 16'd0;
`ifdef M68K_BERR_TIMEOUT_EN
            tmo_q       <= 8'd0;
            berr_n_q    <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            dtack_n_q   <= dtack_n_d;
            avec_n_q    <= avec_n_d;
            dev_req_q   <= dev_req_d;
            dev_we_q    <= dev_we_d;
            dev_be_q    <= dev_be_d;
            dev_addr_q  <= dev_addr_d;
            dev_wdata_q <= dev_wdata_d;
            cpu_din_q   <= cpu_din_d;
`ifdef M68K_BERR_TIMEOUT_EN
            tmo_q       <= tmo_d;
            berr_n_q    <= berr_n_d;
`endif
        end
    end

    assign dtack_n   = dtack_n_q;
    assign avec_n    = avec_n_q;
    assign dev_req   = dev_req_q;
    assign dev_we    = dev_we_q;
    assign dev_be    = dev_be_q;
    assign dev_addr  = dev_addr_q;
    assign dev_wdata = dev_wdata_q;
    assign cpu_din   = cpu_din_q;
`ifdef M68K_BERR_TIMEOUT_EN
    assign berr_n    = berr_n_q;
`else
    assign berr_n    = 1'b1;
`endif

endmodule

// File: doc/m68k_bus_responder.md
Name: m68k_bus_responder

Overview:
- Bus-side responder for the 68000 core: slave end of the asynchronous 68000 bus.
- Watches as_n/uds_n/lds_n/r_w_n/fc/a_in from the CPU and drives dtack_n, berr_n, avec_n and read data back to it.
- Converts each bus cycle into a single-request, ack-based handshake to a device/memory fabric.
- Also answers interrupt-acknowledge cycles with autovector, and optionally ends unanswered cycles with a bus error.

Parameters:
- WAIT_STATES, 0: extra clk cycles inserted between dev_ack and dtack_n assertion (0..15).
- TIMEOUT, 64: clk cycles in REQ without dev_ack before bus error (only with the optional feature; 2..255).

Ports:
- clk  in  1  system clock; the CPU runs on the same clock.
- reset_n  in  1  asynchronous active-low reset.
- a_in  in  24  CPU byte address; bit 0 ignored.
- cpu_dout  in  16  CPU write data.
- cpu_din  out  16  read data to CPU.
- as_n  in  1  address strobe.
- uds_n  in  1  upper data strobe.
- lds_n  in  1  lower data strobe.
- r_w_n  in  1  1 = read, 0 = write.
- fc  in  3  CPU function code.
- dtack_n  out  1  data transfer acknowledge.
- berr_n  out  1  bus error.
- avec_n  out  1  autovector request.
- dev_req  out  1  device request, held until dev_ack.
- dev_we  out  1  write enable.
- dev_be  out  2  byte enables: [1] = ~uds_n, [0] = ~lds_n.
- dev_addr  out  23  word address a_in[23:1].
- dev_wdata  out  16  write data.
- dev_rdata  in  16  read data, valid with dev_ack.
- dev_ack  in  1  one-cycle completion pulse.

Behaviour:
- Reset: asynchronous on reset_n=0. All outputs take reset values immediately: dtack_n=1, berr_n=1, avec_n=1, dev_req=0, dev_we=0, dev_be=0, dev_addr=0, dev_wdata=0, cpu_din=0. State=IDLE, counters=0. Deasserting reset mid-cycle resumes in IDLE; a still-low as_n is treated as a new cycle.
- All outputs are registered. Inputs are sampled on the rising clk edge.
- IACK detect: fc==3'b111 and a_in[19:16]==4'hF.
- IDLE:
  - as_n=0 and IACK: go to IACK.
  - Otherwise, as_n=0 and (uds_n=0 or lds_n=0): latch dev_addr, dev_be, dev_we=~r_w_n and dev_wdata=cpu_dout. Set dev_req=1 and go to REQ.
  - as_n=0 with both strobes high: stay in IDLE. This covers 68000 writes, where the strobes lag AS by one cycle.
- REQ:
  - dev_ack=1: dev_req=0. On a read, cpu_din<=dev_rdata. Load the wait counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, else to ACK.
  - as_n=1 before dev_ack (aborted cycle): dev_req=0 next edge, go to IDLE. Later acks are ignored.
  - dev_ack takes priority over a simultaneous as_n rise. In that case the cycle completes to ACK, then immediately releases.
- WAIT: decrement each cycle; at 1, go to ACK. as_n=1 here: go to IDLE.
- ACK:
  - dtack_n=0 for as long as as_n=0.
  - First edge with as_n=1: dtack_n=1, go to IDLE.
  - cpu_din holds its value until the next read completes.
- IACK:
  - avec_n=0, no dev_req.
  - When as_n=1: avec_n=1, go to IDLE.
- BERR (optional feature only):
  - berr_n=0, dev_req=0, dtack_n stays 1.
  - When as_n=1: berr_n=1, go to IDLE.
- Latency: as_n/strobe sampled at edge N gives dev_req=1 after edge N. dev_ack sampled at edge M gives dtack_n=0 after edge M+1+WAIT_STATES. The minimum read response is therefore 2 clks from request to dtack.
- Never assert dtack_n, berr_n and avec_n together. dev_ack outside REQ is ignored.

Optional Feature:
- Macro: M68K_BERR_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without dev_ack.
  - When the count reaches TIMEOUT-1 and there is still no dev_ack: dev_req=0, go to BERR.
  - dev_ack on the same edge wins over the timeout.
- Undefined: no counter and no BERR state; berr_n is tied to 1 and REQ waits indefinitely.

Test Plan:
- Word read, a_in=24'h00_1234, both strobes low, WAIT_STATES=0, dev_ack on the 3rd REQ cycle with dev_rdata=16'hBEEF -> dev_addr=23'h00091A, dev_be=2'b11, dtack_n low 1 clk after the ack, cpu_din=16'hBEEF, dtack_n high 1 clk after as_n rises.
- Byte write of cpu_dout=16'h00A5 with only lds_n low, strobes asserted 1 clk after as_n -> dev_req starts the cycle after the strobe, dev_we=1, dev_be=2'b01, dev_wdata=16'h00A5.
- WAIT_STATES=3, immediate dev_ack -> dtack_n asserts exactly 4 clks after the ack edge.
- IACK cycle, fc=3'b111, a_in[19:16]=4'hF -> avec_n=0 and dev_req stays 0; avec_n=1 one clk after as_n rises.
- as_n released before dev_ack, then a late dev_ack pulse -> dev_req drops, dtack_n never asserts, FSM in IDLE. Also: reset_n pulsed low in ACK -> dtack_n=1 immediately.
- With M68K_BERR_TIMEOUT_EN and TIMEOUT=16, no dev_ack -> berr_n=0 after 16 REQ cycles, dev_req=0; released with as_n. Without the macro -> berr_n stays 1 and dev_req stays asserted.
